// File: rtl/complex_interp_pkg.sv
// Shared definitions for the x2 complex interpolator.
//   - FSM state encodings (2'd3 is unused and decodes as S_WAIT)
//   - mid_sum: floor((a + b) / 2) on sign-extended operands
package complex_interp_pkg;

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_MID  = 2'd1;
    localparam logic [1:0] S_SAMP = 2'd2;

    // Operands arrive sign-extended to 32 bits, so the 33-bit sum cannot
    // overflow. The arithmetic shift rounds toward minus infinity. The
    // caller truncates back to its own width, which is always exact
    // because the midpoint lies between the two operands.
    function automatic logic signed [31:0] mid_sum(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return 32'(($signed({a[31], a}) + $signed({b[31], b})) >>> 1);
    endfunction

endpackage

// File: rtl/complex_midpoint.sv
// Combinational complex midpoint: mid = floor((a + b) / 2) per component.
//   aRe/aIm, bRe/bIm : signed operands, DATA_WIDTH bits each
//   midRe/midIm      : signed midpoint, DATA_WIDTH bits each
module complex_midpoint
    import complex_interp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] aRe,
    input  logic [DATA_WIDTH-1:0] aIm,
    input  logic [DATA_WIDTH-1:0] bRe,
    input  logic [DATA_WIDTH-1:0] bIm,
    output logic [DATA_WIDTH-1:0] midRe,
    output logic [DATA_WIDTH-1:0] midIm
);

    assign midRe = DATA_WIDTH'(mid_sum(32'($signed(aRe)), 32'($signed(bRe))));
    assign midIm = DATA_WIDTH'(mid_sum(32'($signed(aIm)), 32'($signed(bIm))));

endmodule

// File: rtl/complex_sample_reg.sv
// Complex sample register: holds a real/imag pair.
//   clk, rstn : clock, async active-low reset (clears to 0)
//   clrh      : sync clear, has priority over enh
//   enh       : load dataRe_i/dataIm_i
//   dataRe_o/dataIm_o : registered sample
module complex_sample_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clrh,
    input  logic                  enh,
    input  logic [DATA_WIDTH-1:0] dataRe_i,
    input  logic [DATA_WIDTH-1:0] dataIm_i,
    output logic [DATA_WIDTH-1:0] dataRe_o,
    output logic [DATA_WIDTH-1:0] dataIm_o
);

    logic [DATA_WIDTH-1:0] re_d, re_q, im_d, im_q;

    always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (clrh) begin
            re_d = '0;
            im_d = '0;
        end else if (enh) begin
            re_d = dataRe_i;
            im_d = dataIm_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            re_q <= '0;
            im_q <= '0;
        end else begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign dataRe_o = re_q;
    assign dataIm_o = im_q;

endmodule

// File: rtl/complex_interp_x2.sv
// Streaming x2 linear interpolator for complex samples. Each accepted
// sample produces two outputs: midpoint(prev, cur), then cur.
//   clk, rstn          : clock, async active-low reset
//   clrh               : sync clear back to reset state, highest priority
//   valid_i / ready_o  : input handshake (ready_o is combinational)
//   dataRe_i/dataIm_i  : input sample
//   valid_o / ready_i  : output handshake
//   dataRe_o/dataIm_o  : registered output sample
module complex_interp_x2
    import complex_interp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clrh,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] dataRe_i,
    input  logic [DATA_WIDTH-1:0] dataIm_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dataRe_o,
    output logic [DATA_WIDTH-1:0] dataIm_o
);

    logic [1:0]            state_d, state_q;
    logic [DATA_WIDTH-1:0] cur_re_d, cur_re_q, cur_im_d, cur_im_q;
    logic [DATA_WIDTH-1:0] out_re_d, out_re_q, out_im_d, out_im_q;
    logic [DATA_WIDTH-1:0] prev_re, prev_im;
    logic [DATA_WIDTH-1:0] a_re, a_im, mid_re, mid_im;
    logic                  st_mid, st_samp, st_wait;
    logic                  accept, xfer, prev_en;

    assign st_mid  = (state_q == S_MID);
    assign st_samp = (state_q == S_SAMP);
    assign st_wait = !st_mid && !st_samp;   // also covers the unused code

    assign ready_o = st_wait || (st_samp && ready_i);
    assign valid_o = st_mid || st_samp;
    assign accept  = valid_i && ready_o;
    assign xfer    = valid_o && ready_i;

    // cur becomes the previous sample once it has been handed downstream.
    assign prev_en = st_samp && xfer;

    complex_sample_reg #(.DATA_WIDTH(DATA_WIDTH)) u_prev (
        .clk      (clk),
        .rstn     (rstn),
        .clrh     (clrh),
        .enh      (prev_en),
        .dataRe_i (cur_re_q),
        .dataIm_i (cur_im_q),
        .dataRe_o (prev_re),
        .dataIm_o (prev_im)
    );

    // An accept in S_SAMP coincides with prev<-cur, so take cur directly
    // instead of the not-yet-updated prev register.
    assign a_re = st_samp ? cur_re_q : prev_re;
    assign a_im = st_samp ? cur_im_q : prev_im;

    complex_midpoint #(.DATA_WIDTH(DATA_WIDTH)) u_mid (
        .aRe   (a_re),
        .aIm   (a_im),
        .bRe   (dataRe_i),
        .bIm   (dataIm_i),
        .midRe (mid_re),
        .midIm (mid_im)
    );

    always_comb begin
        state_d  = state_q;
        cur_re_d = cur_re_q;
        cur_im_d = cur_im_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (clrh) begin
            state_d  = S_WAIT;
            cur_re_d = '0;
            cur_im_d = '0;
            out_re_d = '0;
            out_im_d = '0;
        end else if (st_mid) begin
            if (xfer) begin
                out_re_d = cur_re_q;
                out_im_d = cur_im_q;
                state_d  = S_SAMP;
            end
        end else if (st_samp) begin
            if (xfer && accept) begin
                cur_re_d = dataRe_i;
                cur_im_d = dataIm_i;
                out_re_d = mid_re;
                out_im_d = mid_im;
                state_d  = S_MID;
            end else if (xfer) begin
                state_d  = S_WAIT;
            end
        end else if (accept) begin
            cur_re_d = dataRe_i;
            cur_im_d = dataIm_i;
            out_re_d = mid_re;
            out_im_d = mid_im;
            state_d  = S_MID;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_WAIT;
            cur_re_q <= '0;
            cur_im_q <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_re_q <= cur_re_d;
            cur_im_q <= cur_im_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
        end
    end

    assign dataRe_o = out_re_q;
    assign dataIm_o = out_im_q;

endmodule

// File: tb/tb_complex_interp_x2.sv
// Scoreboard bench for complex_interp_x2 (DATA_WIDTH = 8).
module tb_complex_interp_x2;

    logic       clk, rstn, clrh, valid_i, ready_o, valid_o, ready_i;
    logic [7:0] dataRe_i, dataIm_i, dataRe_o, dataIm_o;

    complex_interp_x2 #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clrh     (clrh),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .dataRe_i (dataRe_i),
        .dataIm_i (dataIm_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .dataRe_o (dataRe_o),
        .dataIm_o (dataIm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int q_re[$];
    int q_im[$];
    int prev_re = 0;
    int prev_im = 0;
    bit stream_on = 1'b0;
    bit prev_rdy = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // floor((a+b)/2) via integer division with a correction for negatives
    function automatic int mid_m(input int a, input int b);
        int s;
        s = a + b;
        if (s < 0 && (s % 2) != 0) return s / 2 - 1;
        return s / 2;
    endfunction

    function automatic int sre();
        return $signed(dataRe_o);
    endfunction
    function automatic int sim();
        return $signed(dataIm_o);
    endfunction

    task automatic send(input int re, input int im);
        int n;
        n = 0;
        valid_i  = 1'b1;
        dataRe_i = 8'(re);
        dataIm_i = 8'(im);
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("send_ready_timeout", int'(ready_o), 1);
        end else begin
            q_re.push_back(mid_m(prev_re, re));
            q_im.push_back(mid_m(prev_im, im));
            q_re.push_back(re);
            q_im.push_back(im);
            prev_re = re;
            prev_im = im;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q_re.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q_re.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic flush_model();
        q_re.delete();
        q_im.delete();
        prev_re = 0;
        prev_im = 0;
    endtask

    // Output monitor: compare every transfer against the scoreboard.
    always @(negedge clk) begin
        if (rstn && !clrh && valid_o && ready_i) begin
            if (q_re.size() == 0) begin
                chk("sb_underflow", q_re.size(), 1);
            end else begin
                chk("out_re", sre(), q_re.pop_front());
                chk("out_im", sim(), q_im.pop_front());
            end
        end
        if (stream_on) begin
            chk("stream_valid_o", int'(valid_o), 1);
            chk("stream_ready_toggle", int'(ready_o), int'(!prev_rdy));
            prev_rdy = ready_o;
        end
    end

    initial begin
        rstn = 1'b0; clrh = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        dataRe_i = '0; dataIm_i = '0;
        #1;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_ready_o", int'(ready_o), 1);
        chk("rst_re", sre(), 0);
        chk("rst_im", sim(), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        ready_i = 1'b1;

        // basic: (10,-4) -> (5,-2),(10,-4); (20,-8) -> (15,-6),(20,-8)
        send(10, -4);
        send(20, -8);
        drain();

        // rounding toward -inf and extremes
        send(3, -3);
        send(4, -4);
        send(127, -128);
        send(127, -128);
        drain();

        // backpressure in S_MID: prev (127,-128), input (50,10) -> (88,-59)
        ready_i = 1'b0;
        send(50, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid_o", int'(valid_o), 1);
            chk("bp_ready_o", int'(ready_o), 0);
            chk("bp_re", sre(), 88);
            chk("bp_im", sim(), -59);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        drain();

        // clear in idle, then continuous stream 0,2,4,...
        clrh = 1'b1;
        @(posedge clk); #1;
        clrh = 1'b0;
        flush_model();
        for (int i = 0; i < 10; i++) begin
            send(2 * i, -2 * i);
            if (i == 0) begin
                stream_on = 1'b1;
                prev_rdy  = 1'b1;
            end
        end
        stream_on = 1'b0;
        drain();

        // clear while in S_MID with prev = 20
        send(20, 0);
        drain();
        ready_i = 1'b0;
        send(40, 0);
        @(negedge clk);
        chk("pre_clr_valid_o", int'(valid_o), 1);
        chk("pre_clr_re", sre(), 30);
        @(posedge clk); #1;
        clrh = 1'b1;
        @(posedge clk); #1;
        clrh = 1'b0;
        flush_model();
        @(negedge clk);
        chk("clr_valid_o", int'(valid_o), 0);
        chk("clr_ready_o", int'(ready_o), 1);
        chk("clr_re", sre(), 0);
        chk("clr_im", sim(), 0);
        @(posedge clk); #1;
        ready_i = 1'b1;
        send(8, 0);
        drain();

        // async reset while in S_SAMP
        ready_i = 1'b0;
        send(12, 2);
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        chk("pre_rst_re", sre(), 12);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid_o", int'(valid_o), 0);
        chk("arst_ready_o", int'(ready_o), 1);
        chk("arst_re", sre(), 0);
        chk("arst_im", sim(), 0);
        flush_model();
        @(posedge clk); #1;
        rstn = 1'b1;
        ready_i = 1'b1;
        send(6, -5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
